// File: rtl/hub75_scanner.sv
// HUB75 panel scanner: walks a 64x32 frame buffer row by row and bit plane by bit plane,
// shifting two rows per pass and holding each plane on the panel for a binary-weighted time.
module hub75_scanner #(
    parameter int unsigned BITS       = 8,
    parameter int unsigned BASE_TICKS = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [9:0]  read_addr,
    output logic        read_en,
    input  logic [31:0] read_data_top,
    input  logic [31:0] read_data_bottom,
    output logic [1:0]  hub75_red,
    output logic [1:0]  hub75_green,
    output logic [1:0]  hub75_blue,
    output logic [3:0]  hub75_addr,
    output logic        hub75_clk,
    output logic        hub75_lat,
    output logic        hub75_oe_n,
    output logic        frame_done
);

    localparam int unsigned TICK_W     = $clog2((BASE_TICKS << 7) + 1);
    localparam logic [2:0]  PLANE_LAST = 3'(BITS - 1);
    localparam logic [2:0]  PLANE_OFS  = 3'(8 - BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT_LOW,
        S_SHIFT_HIGH,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t              r_state;
    logic [3:0]          r_row;
    logic [5:0]          r_col;
    logic [2:0]          r_plane;
    logic [TICK_W-1:0]   r_tick;
    logic [9:0]          r_read_addr;
    logic                r_read_en;
    logic [1:0]          r_red;
    logic [1:0]          r_green;
    logic [1:0]          r_blue;
    logic [3:0]          r_hub_addr;
    logic                r_hub_clk;
    logic                r_lat;
    logic                r_oe_n;
    logic                r_frame_done;

    state_t              w_state_nxt;
    logic [3:0]          w_row_nxt;
    logic [5:0]          w_col_nxt;
    logic [2:0]          w_plane_nxt;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [9:0]          w_read_addr_nxt;
    logic                w_read_en_nxt;
    logic [1:0]          w_red_nxt;
    logic [1:0]          w_green_nxt;
    logic [1:0]          w_blue_nxt;
    logic [3:0]          w_hub_addr_nxt;
    logic                w_hub_clk_nxt;
    logic                w_lat_nxt;
    logic                w_oe_n_nxt;
    logic                w_frame_done_nxt;

    logic [2:0]          w_bit;
    logic [TICK_W-1:0]   w_tick_load;
    logic [7:0]          w_top_r, w_top_g, w_top_b;
    logic [7:0]          w_bot_r, w_bot_g, w_bot_b;
    logic                w_unused_alpha;

    // Channel slices of the pixel words; the top byte carries nothing for the panel
    assign w_top_r        = read_data_top[7:0];
    assign w_top_g        = read_data_top[15:8];
    assign w_top_b        = read_data_top[23:16];
    assign w_bot_r        = read_data_bottom[7:0];
    assign w_bot_g        = read_data_bottom[15:8];
    assign w_bot_b        = read_data_bottom[23:16];
    assign w_unused_alpha = ^{read_data_top[31:24], read_data_bottom[31:24]};

    assign w_bit       = PLANE_OFS + r_plane;
    assign w_tick_load = (TICK_W'(BASE_TICKS) << r_plane) - TICK_W'(1);

    // Next-state and next-output logic; outputs are registered from the upcoming state
    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        w_plane_nxt      = r_plane;
        w_tick_nxt       = r_tick;
        w_read_addr_nxt  = r_read_addr;
        w_read_en_nxt    = 1'b0;
        w_red_nxt        = r_red;
        w_green_nxt      = r_green;
        w_blue_nxt       = r_blue;
        w_hub_addr_nxt   = r_hub_addr;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_FETCH;
                    w_row_nxt   = 4'd0;
                    w_plane_nxt = 3'd0;
                    w_col_nxt   = 6'd0;
                end
            end
            S_FETCH: begin
                w_col_nxt   = 6'd0;
                w_state_nxt = S_SHIFT_LOW;
            end
            S_SHIFT_LOW: begin
                w_red_nxt   = {w_bot_r[w_bit], w_top_r[w_bit]};
                w_green_nxt = {w_bot_g[w_bit], w_top_g[w_bit]};
                w_blue_nxt  = {w_bot_b[w_bit], w_top_b[w_bit]};
                // Prefetch the next column while the panel clock is high
                if (r_col != 6'd63) begin
                    w_read_en_nxt   = 1'b1;
                    w_read_addr_nxt = {r_row, r_col + 6'd1};
                end
                w_state_nxt = S_SHIFT_HIGH;
            end
            S_SHIFT_HIGH: begin
                if (r_col != 6'd63) begin
                    w_col_nxt   = r_col + 6'd1;
                    w_state_nxt = S_SHIFT_LOW;
                end else begin
                    w_col_nxt      = 6'd0;
                    w_hub_addr_nxt = r_row;
                    w_state_nxt    = S_BLANK;
                end
            end
            S_BLANK: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_tick_nxt  = w_tick_load;
                w_state_nxt = S_DISPLAY;
            end
            S_DISPLAY: begin
                if (r_tick != '0) begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end else if (r_plane != PLANE_LAST) begin
                    w_plane_nxt = r_plane + 3'd1;
                    w_state_nxt = S_FETCH;
                end else if (r_row != 4'd15) begin
                    w_plane_nxt = 3'd0;
                    w_row_nxt   = r_row + 4'd1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_plane_nxt      = 3'd0;
                    w_row_nxt        = 4'd0;
                    w_frame_done_nxt = 1'b1;
                    w_state_nxt      = enable ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_state_nxt == S_FETCH) begin
            w_read_en_nxt   = 1'b1;
            w_read_addr_nxt = {w_row_nxt, 6'd0};
        end

        w_hub_clk_nxt = (w_state_nxt == S_SHIFT_HIGH);
        w_lat_nxt     = (w_state_nxt == S_LATCH);
        w_oe_n_nxt    = (w_state_nxt != S_DISPLAY);
    end

    // State, counters and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_row        <= 4'd0;
            r_col        <= 6'd0;
            r_plane      <= 3'd0;
            r_tick       <= '0;
            r_read_addr  <= 10'd0;
            r_read_en    <= 1'b0;
            r_red        <= 2'b00;
            r_green      <= 2'b00;
            r_blue       <= 2'b00;
            r_hub_addr   <= 4'd0;
            r_hub_clk    <= 1'b0;
            r_lat        <= 1'b0;
            r_oe_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_plane      <= w_plane_nxt;
            r_tick       <= w_tick_nxt;
            r_read_addr  <= w_read_addr_nxt;
            r_read_en    <= w_read_en_nxt;
            r_red        <= w_red_nxt;
            r_green      <= w_green_nxt;
            r_blue       <= w_blue_nxt;
            r_hub_addr   <= w_hub_addr_nxt;
            r_hub_clk    <= w_hub_clk_nxt;
            r_lat        <= w_lat_nxt;
            r_oe_n       <= w_oe_n_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign read_addr   = r_read_addr;
    assign read_en     = r_read_en;
    assign hub75_red   = r_red;
    assign hub75_green = r_green;
    assign hub75_blue  = r_blue;
    assign hub75_addr  = r_hub_addr;
    assign hub75_clk   = r_hub_clk;
    assign hub75_lat   = r_lat;
    assign hub75_oe_n  = r_oe_n;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_hub75_scanner.sv
// Directed bench for hub75_scanner: frame RAM model, protocol monitor and scripted scenarios
// covering reset, full-frame timing, enable drop and mid-display reset.
module tb_hub75_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [9:0]  read_addr;
    logic        read_en;
    logic [31:0] rd_top, rd_bot;
    logic [1:0]  hub75_red, hub75_green, hub75_blue;
    logic [3:0]  hub75_addr;
    logic        hub75_clk, hub75_lat, hub75_oe_n, frame_done;

    logic [31:0] mem_top [1024];
    logic [31:0] mem_bot [1024];

    int n_checks = 0;
    int n_fail   = 0;

    logic mon_en    = 1'b0;
    logic mon_clear = 1'b0;

    hub75_scanner dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .read_addr        (read_addr),
        .read_en          (read_en),
        .read_data_top    (rd_top),
        .read_data_bottom (rd_bot),
        .hub75_red        (hub75_red),
        .hub75_green      (hub75_green),
        .hub75_blue       (hub75_blue),
        .hub75_addr       (hub75_addr),
        .hub75_clk        (hub75_clk),
        .hub75_lat        (hub75_lat),
        .hub75_oe_n       (hub75_oe_n),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    // Frame RAM: data appears one clock after the read strobe
    always @(posedge clk) begin
        if (read_en) begin
            rd_top <= mem_top[read_addr];
            rd_bot <= mem_bot[read_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe_n"},  32'(hub75_oe_n), 32'd1);
        check({tag, "_lat"},   32'(hub75_lat), 32'd0);
        check({tag, "_hclk"},  32'(hub75_clk), 32'd0);
        check({tag, "_rgb"},   32'({hub75_red, hub75_green, hub75_blue}), 32'd0);
        check({tag, "_haddr"}, 32'(hub75_addr), 32'd0);
        check({tag, "_ren"},   32'(read_en), 32'd0);
        check({tag, "_raddr"}, 32'(read_addr), 32'd0);
        check({tag, "_fdone"}, 32'(frame_done), 32'd0);
    endtask

    task automatic wait_first_fetch(input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (read_en) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_fetch_seen"}, 32'(found), 32'd1);
        check({tag, "_fetch_addr"}, 32'(read_addr), 32'd0);
    endtask

    // Protocol monitor state
    int         m_row, m_plane, m_col;
    int         ra_row, ra_plane, ra_col;
    int         run_len, lat_len;
    logic [3:0] run_addr;
    logic       prev_hclk, prev_oe, prev_lat;
    logic [31:0] mt, mb;
    logic [5:0]  exp_rgb;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_clear) begin
                m_row = 0; m_plane = 0; m_col = 0;
                ra_row = 0; ra_plane = 0; ra_col = 0;
                run_len = 0; lat_len = 0; run_addr = 4'd0;
                prev_hclk = 1'b0; prev_oe = 1'b1; prev_lat = 1'b0;
            end else if (mon_en) begin
                if (read_en) begin
                    check("raddr_seq", 32'(read_addr), 32'({4'(ra_row), 6'(ra_col)}));
                    ra_col++;
                    if (ra_col == 64) begin
                        ra_col = 0;
                        ra_plane++;
                        if (ra_plane == 8) begin
                            ra_plane = 0;
                            ra_row = (ra_row + 1) % 16;
                        end
                    end
                end
                if (hub75_clk && !prev_hclk) begin
                    mt = mem_top[{4'(m_row), 6'(m_col)}];
                    mb = mem_bot[{4'(m_row), 6'(m_col)}];
                    exp_rgb = {mb[m_plane], mt[m_plane], mb[8+m_plane], mt[8+m_plane],
                               mb[16+m_plane], mt[16+m_plane]};
                    check("rgb", 32'({hub75_red, hub75_green, hub75_blue}), 32'(exp_rgb));
                    if (m_row == 0 && m_plane == 7 && m_col == 0)
                        check("rgb_p7_col0", 32'({hub75_red, hub75_blue}), 32'b0110);
                    m_col++;
                end
                if (hub75_lat && !prev_lat) begin
                    check("rises_per_plane", 32'(m_col), 32'd64);
                    m_col = 0;
                end
                if (hub75_lat) lat_len++;
                if (!hub75_lat && prev_lat) begin
                    check("lat_width", 32'(lat_len), 32'd1);
                    lat_len = 0;
                end
                if (!hub75_oe_n) begin
                    if (prev_oe) begin
                        check("lat_before_oe", 32'(prev_lat), 32'd1);
                        check("oe_row", 32'(hub75_addr), 32'(m_row));
                        run_addr = hub75_addr;
                        run_len = 0;
                    end else begin
                        check("addr_stable", 32'(hub75_addr), 32'(run_addr));
                    end
                    run_len++;
                end else if (!prev_oe) begin
                    check("oe_run_len", 32'(run_len), 32'(1 << m_plane));
                    m_plane++;
                    if (m_plane == 8) begin
                        m_plane = 0;
                        m_row = (m_row + 1) % 16;
                    end
                end
                prev_hclk = hub75_clk;
                prev_oe   = hub75_oe_n;
                prev_lat  = hub75_lat;
            end
        end
    end

    int   cyc, cnt, runs, len;
    bit   hit;
    logic prev_oe_m;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        for (int a = 0; a < 1024; a++) begin
            mem_top[a] = (32'(a) * 32'h9E3779B1) ^ 32'h01234567;
            mem_bot[a] = (32'(a) * 32'h85EBCA6B) + 32'h00000ABC;
        end
        mem_top[0] = 32'h000000FF;
        mem_bot[0] = 32'h00FF0000;

        // Reset held with enable high
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        mon_clear = 1'b1;
        @(posedge clk);
        mon_clear = 1'b0;
        mon_en    = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        wait_first_fetch("start");

        // First full frame
        cyc = 0;
        while (cyc < 25000) begin
            @(negedge clk);
            cyc++;
            if (frame_done) break;
        end
        check("frame1_cycles", 32'(cyc), 32'd20848);
        @(negedge clk);
        check("frame_done_width", 32'(frame_done), 32'd0);
        check("frame_wrap_addr", 32'(read_addr), 32'd0);

        // Second frame, enable dropped during row 5
        cyc = 1;
        hit = 1'b0;
        while (cyc < 25000) begin
            @(negedge clk);
            cyc++;
            if (!hit && hub75_addr == 4'd5 && !hub75_oe_n) begin
                enable = 1'b0;
                hit = 1'b1;
            end
            if (frame_done) break;
        end
        check("en_drop_row5", 32'(hit), 32'd1);
        check("frame2_cycles", 32'(cyc), 32'd20848);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (read_en || !hub75_oe_n || frame_done) cnt++;
        end
        check("idle_quiet", 32'(cnt), 32'd0);
        check("idle_oe_n", 32'(hub75_oe_n), 32'd1);

        // Third frame: reset during row 9, plane 3 display
        @(posedge clk);
        enable = 1'b1;
        runs = 0;
        prev_oe_m = 1'b1;
        cyc = 0;
        while (runs < 76 && cyc < 15000) begin
            @(negedge clk);
            cyc++;
            if (!hub75_oe_n && prev_oe_m) runs++;
            prev_oe_m = hub75_oe_n;
        end
        check("r9p3_reached", 32'(runs), 32'd76);
        repeat (3) @(negedge clk);
        check("r9p3_oe_low", 32'(hub75_oe_n), 32'd0);
        check("r9p3_row", 32'(hub75_addr), 32'd9);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        mon_clear = 1'b1;
        @(posedge clk);
        mon_clear = 1'b0;
        mon_en    = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        wait_first_fetch("restart");
        cyc = 0;
        while (hub75_oe_n && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        len = 0;
        while (!hub75_oe_n && len < 400) begin
            @(negedge clk);
            len++;
        end
        check("restart_plane0_run", 32'(len), 32'd1);
        repeat (2000) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_scanner.md
HUB75_SCANNER -- requirements
Module: hub75_scanner

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning bit planes per colour channel (1..8).
REQ-002 SHALL have parameter BASE_TICKS, default 1, meaning clk cycles of output-enable for plane 0.
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permit scanning.
REQ-006 SHALL have port read_addr  output  10  frame RAM read address {row[3:0], col[5:0]}.
REQ-007 SHALL have port read_en  output  1  frame RAM read strobe.
REQ-008 SHALL have port read_data_top  input  32  pixel for rows 0-15, valid one clk after read_en.
REQ-009 SHALL have port read_data_bottom  input  32  pixel for rows 16-31, same timing.
REQ-010 SHALL have ports hub75_red, hub75_green, hub75_blue  output  2 each  bit0 top half, bit1 bottom half.
REQ-011 SHALL have port hub75_addr  output  4  panel row select.
REQ-012 SHALL have ports hub75_clk, hub75_lat  output  1 each  shift clock, latch.
REQ-013 SHALL have port hub75_oe_n  output  1  output enable, active low.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at frame end (drives RAM buffer_toggle upstream).

Function
REQ-015 Pixel format SHALL be red [7:0], green [15:8], blue [23:16]; [31:24] ignored.
REQ-016 Plane p (0..BITS-1) SHALL use channel bit (8-BITS+p).
REQ-017 States SHALL be IDLE, FETCH, SHIFT_LOW, SHIFT_HIGH, BLANK, LATCH, DISPLAY.
REQ-018 IDLE: oe_n=1, read_en=0; SHALL go to FETCH at row 0, plane 0 when enable=1.
REQ-019 FETCH: read_en=1, read_addr={row,0}, col=0; next SHIFT_LOW.
REQ-020 SHIFT_LOW: hub75_clk=0; rgb outputs SHALL take plane bits of read_data_top/bottom; next SHIFT_HIGH.
REQ-021 SHIFT_HIGH: hub75_clk=1, rgb held; if col<63, read_en=1, read_addr={row,col+1}, col+=1, next SHIFT_LOW; else next BLANK.
REQ-022 hub75_oe_n SHALL be 1 in every state except DISPLAY.
REQ-023 BLANK: hub75_addr SHALL update to row; next LATCH.
REQ-024 LATCH: hub75_lat=1 for exactly this one cycle; next DISPLAY.
REQ-025 DISPLAY: oe_n=0 for exactly BASE_TICKS<<p cycles (down-counter, width sufficient for BASE_TICKS<<7).
REQ-026 DISPLAY end: p<BITS-1 -> p+1, FETCH; else p=0 and row<15 -> row+1, FETCH; else row=0, frame_done=1 for one cycle, then FETCH if enable=1 else IDLE.
REQ-027 Row and column counters SHALL wrap 15->0 and 63->0; read_addr wraps 1023->0 at frame end.
REQ-028 hub75_addr SHALL never change while hub75_oe_n=0.
REQ-029 enable SHALL be sampled only in IDLE and at frame end; deassertion mid-frame completes the frame.
REQ-030 Cycles per plane SHALL be 131 + BASE_TICKS<<p; with defaults, 1303 per row and 20848 per frame.

Reset
REQ-031 On reset_n=0, immediately and regardless of state: state IDLE, oe_n=1, lat=0, hub75_clk=0, rgb=0, hub75_addr=0, read_en=0, read_addr=0, frame_done=0, row=plane=col=0.
REQ-032 Reset mid-shift or mid-DISPLAY SHALL discard progress; after release, scanning restarts at row 0, plane 0.

Verification
REQ-033 Assert reset_n=0 with enable=1 -> all outputs at REQ-031 values; release -> FETCH with read_addr=0 on the second clk.
REQ-034 Top pixel 0x000000FF at col 0, bottom 0x00FF0000 -> in plane 7: red=2'b01, blue=2'b10 on first hub75_clk rise; 64 rises per plane.
REQ-035 Defaults: measure oe_n low run per plane -> 1,2,4,...,128 cycles; hub75_lat one-cycle pulse before each run.
REQ-036 Full frame -> read_addr sequence 0..63 repeated 8x per row, rows 0..15; frame_done single pulse after 20848 cycles; hub75_addr stable during every oe_n=0.
REQ-037 Drop enable mid-row 5 -> frame completes, frame_done pulses, state IDLE with oe_n=1.
REQ-038 Pulse reset_n low during plane 3 DISPLAY of row 9 -> oe_n=1 immediately; restart at read_addr=0, plane 0.
